apb_master_ctrl: RTL
====================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width of the request and APB address.
REQ-002 Parameter DATA_W, default 32, write/read data width.
REQ-003 Parameter FIFO_DEPTH, default 2, request buffer entries; power of two, minimum 2.
REQ-004 Hclk  input  1  single clock; all state updates on the rising edge.
REQ-005 Hresetn  input  1  asynchronous, active-low reset.
REQ-006 valid  input  1  request strobe from the AHB-side front end.
REQ-007 Haddr_temp  input  ADDR_W  request address.
REQ-008 Hwdata_temp  input  DATA_W  request write data.
REQ-009 Hwrite_temp  input  1  request direction; 1 = write, 0 = read.
REQ-010 Hready_out  output  1  request buffer can accept a request this cycle.
REQ-011 Hrdata  output  DATA_W  read data returned from APB.
REQ-012 rdata_valid  output  1  one-cycle pulse qualifying Hrdata.
REQ-013 Hresp  output  1  error flag accompanying rdata_valid or write completion.
REQ-014 Psel, Penable, Pwrite  output  1 each  APB control.
REQ-015 Paddr  output  ADDR_W; Pwdata  output  DATA_W  APB address and write data.
REQ-016 Pready  input  1; Prdata  input  DATA_W; Pslverr  input  1  APB completer response.

Function
REQ-017 A request is pushed on every rising edge where valid=1 and Hready_out=1; valid=1 with Hready_out=0 is dropped, and the front end must hold it.
REQ-018 Hready_out is combinational: 1 when buffer occupancy < FIFO_DEPTH. A pop in the same cycle does not raise it; full blocks the push even when a pop occurs.
REQ-019 The buffer is FIFO-ordered. Occupancy is unchanged on a simultaneous push and pop when not full.
REQ-020 FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
REQ-021 IDLE: if buffer non-empty, go to SETUP at the next edge and load Paddr/Pwdata/Pwrite from the head, with Psel=1 and Penable=0. Otherwise stay in IDLE with Psel=0 and Penable=0.
REQ-022 SETUP: unconditionally go to ACCESS, with Penable=1 and Paddr/Pwdata/Pwrite held.
REQ-023 ACCESS with Pready=0: stay in ACCESS with all APB outputs held.
REQ-024 ACCESS with Pready=1: pop the head, drive rdata_valid=1 for the next cycle, and load Hrdata=Prdata on reads; Hrdata is unchanged on writes. Then:
  - if the buffer still holds an entry after the pop, go to SETUP with Penable=0, Psel=1, and the new head loaded;
  - otherwise go to IDLE with Psel=0.
REQ-025 Latency with an empty buffer and Pready=1: push at edge N; Psel=1 after edge N+1; Penable=1 after edge N+2; rdata_valid=1 after edge N+3.
REQ-026 Back-to-back requests cost 2 cycles each with no IDLE cycle between them.
REQ-027 Pwdata is don't-care on reads and is still driven from the buffer.

Reset
REQ-028 Hresetn=0 asynchronously forces IDLE, buffer empty, and all outputs 0: Psel, Penable, Pwrite, Paddr, Pwdata, Hrdata, rdata_valid, Hresp. Hready_out is 1.
REQ-029 Reset during SETUP or ACCESS abandons the transfer. Psel and Penable drop without waiting for a clock, and no rdata_valid is generated.

Configuration
REQ-030 With macro APB_PSLVERR_EN defined, Hresp is loaded from Pslverr at every ACCESS completion and is valid alongside rdata_valid.
REQ-031 Without APB_PSLVERR_EN, Pslverr is ignored and Hresp is constant 0.

Structure
REQ-032 Shared package bridge_pkg holds:
  - the APB state typedef (IDLE/SETUP/ACCESS);
  - the default ADDR_W/DATA_W constants;
  - the request record: addr, wdata, write.
REQ-033 The buffer is sub-module bridge_req_fifo, with push/pop/full/empty/count ports. The FSM and output registers stay in apb_master_ctrl.

Verification
REQ-034 Single write: push addr=0x10, data=0xA5A5A5A5, write=1, Pready=1 → Psel at N+1; Penable at N+2 with Paddr=0x10 and Pwdata=0xA5A5A5A5; rdata_valid at N+3.
REQ-035 Single read with wait states: addr=0x20, Pready low for 3 ACCESS cycles, Prdata=0x12345678 → ACCESS held 4 cycles with outputs stable; Hrdata=0x12345678 with rdata_valid pulsed once.
REQ-036 Backpressure: Pready=0, push 3 requests on consecutive cycles → Hready_out=0 after 2 pushes and the third is not accepted. After Pready=1, addresses appear on Paddr in push order.
REQ-037 Back-to-back: 2 buffered writes (0x30, 0x34), Pready=1 → SETUP, ACCESS, SETUP, ACCESS with no IDLE cycle and Psel continuously 1.
REQ-038 Reset mid-ACCESS: assert Hresetn=0 between edges → Psel, Penable and Paddr are 0 immediately, Hready_out=1, and there is no rdata_valid after release.
REQ-039 With APB_PSLVERR_EN defined, a read with Pslverr=1 at completion → Hresp=1 alongside rdata_valid. Without the macro, Hresp=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared APB state encoding, default widths and request record
package bridge_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef logic [1:0] apb_state_t;
  localparam apb_state_t IDLE   = 2'd0;
  localparam apb_state_t SETUP  = 2'd1;
  localparam apb_state_t ACCESS = 2'd2;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic                  write;
  } req_t;
endpackage

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: request-side and APB-side bus bundle; master = controller, slave = its environment
interface apb_master_ctrl_if
  import bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              valid;
  logic [ADDR_W-1:0] Haddr_temp;
  logic [DATA_W-1:0] Hwdata_temp;
  logic              Hwrite_temp;
  logic              Hready_out;
  logic [DATA_W-1:0] Hrdata;
  logic              rdata_valid;
  logic              Hresp;
  logic              Psel;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Pready;
  logic [DATA_W-1:0] Prdata;
  logic              Pslverr;
  modport master (
    input  valid, Haddr_temp, Hwdata_temp, Hwrite_temp, Pready, Prdata, Pslverr,
    output Hready_out, Hrdata, rdata_valid, Hresp, Psel, Penable, Pwrite, Paddr, Pwdata
  );
  modport slave (
    output valid, Haddr_temp, Hwdata_temp, Hwrite_temp, Pready, Prdata, Pslverr,
    input  Hready_out, Hrdata, rdata_valid, Hresp, Psel, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/bridge_req_fifo.sv
// bridge_req_fifo: request buffer; exposes head and the entry behind it for back-to-back issue
module bridge_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [W-1:0]             nxt_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rp_q, wp_q;
  logic [CW-1:0] cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rp_q];
  assign nxt_o   = mem_q[rp_q + AW'(1)];
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: buffered request to APB master FSM with registered APB outputs
// Define APB_PSLVERR_EN to return Pslverr on Hresp; otherwise Hresp stays 0.
module apb_master_ctrl
  import bridge_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  apb_master_ctrl_if.master    bus
);
  localparam int W  = ADDR_W + DATA_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d, pen_q, pen_d, rv_q, rv_d, hresp_q, hresp_d;
  logic [W-1:0]      req_q, req_d, head, nxt;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              full, empty, push, pop, more;
  logic [CW-1:0]     count;
  assign push = bus.valid & ~full;
  assign pop  = state_q == ACCESS && bus.Pready;
  // the entry behind the head is only usable if it was already stored before this edge
  assign more = count > CW'(1);
  bridge_req_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Hclk), .rst_n(Hresetn), .push_i(push), .pop_i(pop),
    .din_i({bus.Haddr_temp, bus.Hwdata_temp, bus.Hwrite_temp}),
    .dout_o(head), .nxt_o(nxt), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_comb begin
    state_d  = state_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    req_d    = req_q;
    rv_d     = 1'b0;
    hrdata_d = hrdata_q;
    hresp_d  = hresp_q;
    if (state_q == IDLE && !empty) begin
      state_d = SETUP;
      psel_d  = 1'b1;
      req_d   = head;
    end else if (state_q == SETUP) begin
      state_d = ACCESS;
      pen_d   = 1'b1;
    end else if (pop) begin
      rv_d     = 1'b1;
      hrdata_d = req_q[0] ? hrdata_q : bus.Prdata;
`ifdef APB_PSLVERR_EN
      hresp_d  = bus.Pslverr;
`else
      hresp_d  = 1'b0;
`endif
      state_d  = more ? SETUP : IDLE;
      psel_d   = more;
      pen_d    = 1'b0;
      req_d    = more ? nxt : req_q;
    end
  end
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) begin
      state_q  <= IDLE;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      req_q    <= '0;
      rv_q     <= 1'b0;
      hrdata_q <= '0;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      req_q    <= req_d;
      rv_q     <= rv_d;
      hrdata_q <= hrdata_d;
      hresp_q  <= hresp_d;
    end
  assign bus.Hready_out  = ~full;
  assign bus.Psel        = psel_q;
  assign bus.Penable     = pen_q;
  assign bus.Paddr       = req_q[W-1 -: ADDR_W];
  assign bus.Pwdata      = req_q[DATA_W:1];
  assign bus.Pwrite      = req_q[0];
  assign bus.Hrdata      = hrdata_q;
  assign bus.rdata_valid = rv_q;
  assign bus.Hresp       = hresp_q;
endmodule
